// File: rtl/muldiv_sched.sv
// muldiv_sched: runs one mult/div on the shared core, stalls the front end, then steals the regfile write port
module muldiv_sched #(
   parameter int TIMEOUT    = 40,
   parameter int MUL_STATUS = 4,
   parameter int DIV_STATUS = 5
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        issue_mul_i,
   input  logic        issue_div_i,
   input  logic [4:0]  issue_rd_i,
   output logic        core_ctrl_mult_o,
   output logic        core_ctrl_div_o,
   input  logic        core_ready_i,
   input  logic        core_exception_i,
   input  logic [31:0] core_result_i,
   output logic        stall_o,
   output logic        wb_steal_o,
   output logic [4:0]  wb_reg_o,
   output logic [31:0] wb_data_o,
   output logic        busy_o
);
   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST    = CW'(TIMEOUT - 1);
   localparam logic [31:0]   MUL_ERR = 32'(MUL_STATUS);
   localparam logic [31:0]   DIV_ERR = 32'(DIV_STATUS);
   localparam logic [4:0]    RSTATUS = 5'd30;

   typedef enum logic [1:0] {IDLE, START, RUN, WB} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          div_q;
   logic [4:0]    rd_q;
   logic          mul_pulse_q;
   logic          div_pulse_q;
   logic          wb_steal_q;
   logic [4:0]    wb_reg_q;
   logic [31:0]   wb_data_q;
   logic [31:0]   err_code;

   assign err_code = div_q ? DIV_ERR : MUL_ERR;

   // Sequencer: all outputs are registered and loaded on the transition into the state that owns them
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         div_q       <= 1'b0;
         rd_q        <= '0;
         mul_pulse_q <= 1'b0;
         div_pulse_q <= 1'b0;
         wb_steal_q  <= 1'b0;
         wb_reg_q    <= '0;
         wb_data_q   <= '0;
      end else begin
         mul_pulse_q <= 1'b0;
         div_pulse_q <= 1'b0;
         wb_steal_q  <= 1'b0;
         wb_reg_q    <= '0;
         wb_data_q   <= '0;
         case (state_q)
            IDLE: if (issue_mul_i || issue_div_i) begin
               state_q     <= START;
               div_q       <= issue_div_i;
               rd_q        <= issue_rd_i;
               cnt_q       <= '0;
               mul_pulse_q <= !issue_div_i;
               div_pulse_q <= issue_div_i;
            end
            START: state_q <= RUN;
            RUN: begin
               cnt_q <= cnt_q + 1'b1;
               if (core_ready_i) begin
                  state_q    <= WB;
                  wb_steal_q <= core_exception_i || (rd_q != 5'd0);
                  wb_reg_q   <= core_exception_i ? RSTATUS : rd_q;
                  wb_data_q  <= core_exception_i ? err_code : core_result_i;
               end else if (cnt_q == LAST) begin
                  state_q    <= WB;
                  wb_steal_q <= 1'b1;
                  wb_reg_q   <= RSTATUS;
                  wb_data_q  <= err_code;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign core_ctrl_mult_o = mul_pulse_q;
   assign core_ctrl_div_o  = div_pulse_q;
   assign wb_steal_o       = wb_steal_q;
   assign wb_reg_o         = wb_reg_q;
   assign wb_data_o        = wb_data_q;
   assign busy_o           = state_q != IDLE;
   assign stall_o          = issue_mul_i | issue_div_i | busy_o;
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: random and directed mult/div operations checked against a per-cycle timeline model
module tb_muldiv_sched;
   localparam int TIMEOUT    = 40;
   localparam int MUL_STATUS = 4;
   localparam int DIV_STATUS = 5;
   localparam int N          = 8192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        issue_mul = 1'b0;
   logic        issue_div = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        core_ready = 1'b0;
   logic        core_exception = 1'b0;
   logic [31:0] core_result = '0;
   logic        core_ctrl_mult;
   logic        core_ctrl_div;
   logic        stall;
   logic        wb_steal;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        busy;

   muldiv_sched #(.TIMEOUT(TIMEOUT), .MUL_STATUS(MUL_STATUS), .DIV_STATUS(DIV_STATUS)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_mul_i(issue_mul), .issue_div_i(issue_div), .issue_rd_i(issue_rd),
      .core_ctrl_mult_o(core_ctrl_mult), .core_ctrl_div_o(core_ctrl_div),
      .core_ready_i(core_ready), .core_exception_i(core_exception), .core_result_i(core_result),
      .stall_o(stall), .wb_steal_o(wb_steal), .wb_reg_o(wb_reg), .wb_data_o(wb_data), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Expected outputs per absolute cycle; untouched cycles mean "idle, everything zero"
   bit          exp_busy [N];
   bit          exp_pm   [N];
   bit          exp_pd   [N];
   bit          exp_steal[N];
   logic [4:0]  exp_reg  [N];
   logic [31:0] exp_data [N];

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int n_stall = 0, n_pm = 0, n_pd = 0, n_steal = 0;
   logic [4:0]  last_reg = '0;
   logic [31:0] last_data = '0;

   initial for (int i = 0; i < N; i++) begin exp_reg[i] = '0; exp_data[i] = '0; end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the timeline, plus running tallies used for literal checks
   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("stall", 32'(stall), 32'(issue_mul | issue_div | exp_busy[cyc]));
      chk("ctrl_mult", 32'(core_ctrl_mult), 32'(exp_pm[cyc]));
      chk("ctrl_div", 32'(core_ctrl_div), 32'(exp_pd[cyc]));
      chk("wb_steal", 32'(wb_steal), 32'(exp_steal[cyc]));
      chk("wb_reg", 32'(wb_reg), 32'(exp_reg[cyc]));
      chk("wb_data", wb_data, exp_data[cyc]);
      if (stall) n_stall++;
      if (core_ctrl_mult) n_pm++;
      if (core_ctrl_div) n_pd++;
      if (wb_steal) begin n_steal++; last_reg = wb_reg; last_data = wb_data; end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         issue_mul = 0; issue_div = 0; issue_rd = '0; core_ready = 0;
      end
   endtask

   // One operation: k = RUN cycle in which ready rises (k > TIMEOUT means never); rst_at != 0 aborts by reset
   task automatic do_op(input bit m, input bit d, input logic [4:0] rd, input int k, input bit exc,
                        input logic [31:0] res, input bit inject, input bit start_rdy, input int rst_at);
      int t, kk, wbc;
      bit err;
      @(posedge clk); #1;
      t   = cyc;
      kk  = (k >= 1 && k <= TIMEOUT) ? k : TIMEOUT;
      wbc = t + 2 + kk;
      err = (k > TIMEOUT) || exc;
      for (int c = t + 1; c <= wbc; c++) exp_busy[c] = 1;
      if (d) exp_pd[t+1] = 1; else exp_pm[t+1] = 1;
      exp_steal[wbc] = err || (rd != 5'd0);
      exp_reg[wbc]   = err ? 5'd30 : rd;
      exp_data[wbc]  = err ? (d ? 32'(DIV_STATUS) : 32'(MUL_STATUS)) : res;
      issue_mul = m; issue_div = d; issue_rd = rd; core_ready = 0;
      for (int c = t + 1; c <= wbc; c++) begin
         @(posedge clk); #1;
         issue_mul = 0; issue_div = 0; issue_rd = 5'($urandom);
         if (inject && $urandom_range(0, 2) == 0) begin
            issue_mul = 1'($urandom); issue_div = 1'($urandom);
         end
         core_ready = (k <= TIMEOUT && c == t + 1 + k) || (start_rdy && c == t + 1);
         core_exception = (c == t + 1 + k) ? exc : 1'($urandom);
         core_result    = (c == t + 1 + k) ? res : $urandom;
         if (rst_at != 0 && c == t + rst_at) begin
            issue_mul = 0; issue_div = 0;
            core_ready = 1; core_exception = 0; core_result = res;
            for (int x = c + 1; x < c + 64; x++) begin
               exp_busy[x] = 0; exp_pm[x] = 0; exp_pd[x] = 0; exp_steal[x] = 0; exp_reg[x] = '0; exp_data[x] = '0;
            end
            #6 rst_n = 0;
            #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_steal", 32'(wb_steal), 0);
            chk("rst_wb_data", wb_data, 0);
            chk("rst_ctrl", 32'({core_ctrl_mult, core_ctrl_div}), 0);
            @(posedge clk); #1;
            chk("rst_edge_steal", 32'(wb_steal), 0);
            chk("rst_edge_busy", 32'(busy), 0);
            core_ready = 0;
            @(posedge clk); #1;
            rst_n = 1;
            return;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int s_stall, s_pm, s_pd, s_steal;
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      idle(2);

      // mult rd=3, ready in third RUN cycle, result 0x18
      s_stall = n_stall; s_pm = n_pm; s_steal = n_steal;
      do_op(1, 0, 5'd3, 3, 0, 32'h18, 0, 0, 0);
      idle(1);
      chk("t1_stall_cycles", 32'(n_stall - s_stall), 6);
      chk("t1_mult_pulses", 32'(n_pm - s_pm), 1);
      chk("t1_steals", 32'(n_steal - s_steal), 1);
      chk("t1_wb_reg", 32'(last_reg), 3);
      chk("t1_wb_data", last_data, 32'h18);

      // div rd=7 with exception, ready also seen during START
      s_steal = n_steal; s_pd = n_pd;
      do_op(0, 1, 5'd7, 2, 1, 32'hdead_beef, 0, 1, 0);
      idle(1);
      chk("t2_steals", 32'(n_steal - s_steal), 1);
      chk("t2_div_pulses", 32'(n_pd - s_pd), 1);
      chk("t2_wb_reg", 32'(last_reg), 30);
      chk("t2_wb_data", last_data, 5);

      // mult rd=0: sequence runs, no write
      s_stall = n_stall; s_steal = n_steal;
      do_op(1, 0, 5'd0, 4, 0, 32'h1234, 0, 0, 0);
      idle(1);
      chk("t3_stall_cycles", 32'(n_stall - s_stall), 7);
      chk("t3_steals", 32'(n_steal - s_steal), 0);

      // div timeout
      s_stall = n_stall; s_steal = n_steal;
      do_op(0, 1, 5'd12, TIMEOUT + 10, 0, 32'h0, 0, 0, 0);
      idle(1);
      chk("t4_stall_cycles", 32'(n_stall - s_stall), TIMEOUT + 3);
      chk("t4_steals", 32'(n_steal - s_steal), 1);
      chk("t4_wb_reg", 32'(last_reg), 30);
      chk("t4_wb_data", last_data, 5);

      // back-to-back mults with spurious issue pulses while busy
      s_pm = n_pm; s_pd = n_pd; s_steal = n_steal;
      do_op(1, 0, 5'd1, 2, 0, 32'h11, 1, 0, 0);
      do_op(1, 0, 5'd2, 2, 0, 32'h22, 1, 0, 0);
      idle(1);
      chk("t5_mult_pulses", 32'(n_pm - s_pm), 2);
      chk("t5_div_pulses", 32'(n_pd - s_pd), 0);
      chk("t5_steals", 32'(n_steal - s_steal), 2);
      chk("t5_wb_reg", 32'(last_reg), 2);
      chk("t5_wb_data", last_data, 32'h22);

      // ready on the very last RUN cycle beats the timeout; both issue bits -> div
      do_op(1, 1, 5'd9, TIMEOUT, 0, 32'hcafe_f00d, 0, 0, 0);
      idle(1);
      chk("t6_wb_data", last_data, 32'hcafe_f00d);

      // reset mid-RUN with ready on the same edge
      s_steal = n_steal;
      do_op(1, 0, 5'd9, 5, 0, 32'h5555, 0, 0, 4);
      idle(2);
      chk("t7_steals", 32'(n_steal - s_steal), 0);

      // randomized operations
      for (int i = 0; i < 30; i++) begin
         int sel, r, k;
         sel = $urandom_range(0, 2);
         r   = $urandom_range(0, 9);
         k   = (r == 0) ? TIMEOUT + 5 : (r == 1) ? TIMEOUT : $urandom_range(1, 8);
         do_op(sel != 1, sel != 0, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), k,
               $urandom_range(0, 3) == 0, $urandom, 1'($urandom), 1'($urandom), 0);
         idle($urandom_range(0, 2));
      end
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multicycle multiply/divide scheduler for the 5-stage pipeline. It accepts a mult or div issued from the Execute stage and pulses the start control of the shared multiplier/divider core. It stalls the front of the pipeline while the core runs. When the core finishes, it takes the regfile write port for exactly one cycle to write either the result to rd or an error code to $r30 ($rstatus).

## Interface
Parameters:
- TIMEOUT, 40: maximum RUN cycles before the operation is aborted as an error
- MUL_STATUS, 4: value written to $r30 on a mult exception or timeout
- DIV_STATUS, 5: value written to $r30 on a div exception or timeout

Ports:
- clock  in  1  master clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; returns the block to IDLE
- issue_mul  in  1  X-stage holds a mult this cycle
- issue_div  in  1  X-stage holds a div this cycle
- issue_rd  in  5  destination register of the issuing instruction
- core_ctrl_mult  out  1  one-cycle start pulse to the core, mult
- core_ctrl_div  out  1  one-cycle start pulse to the core, div
- core_ready  in  1  core result valid
- core_exception  in  1  core overflow / divide-by-zero, qualified by core_ready
- core_result  in  32  core result, qualified by core_ready
- stall  out  1  freeze PC and F/D; X inserts a bubble behind the op
- wb_steal  out  1  override the regfile write port this cycle
- wb_reg  out  5  register written when wb_steal=1
- wb_data  out  32  data written when wb_steal=1
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: no operation in flight.
  - START: issues the core pulse.
  - RUN: waits for the core.
  - WB: owns the write port.
- IDLE -> START when issue_mul or issue_div is sampled high at a clock edge.
  - Latch op type (div wins if both are high), issue_rd, and clear the cycle counter.
- START, one cycle:
  - core_ctrl_mult or core_ctrl_div = 1 according to the latched op; the other stays 0.
  - core_ready is ignored in this cycle.
  - Next state is RUN.
- RUN:
  - Counter increments each cycle.
  - If core_ready=1: latch core_result and core_exception, go to WB.
  - Else if counter reaches TIMEOUT-1: latch error=1, go to WB.
  - core_ready and the timeout in the same cycle: core_ready wins.
- WB, one cycle, then IDLE:
  - wb_steal = 1.
  - No error: wb_reg = latched rd, wb_data = latched result.
  - Error: wb_reg = 30, wb_data = MUL_STATUS or DIV_STATUS, zero-extended to 32 bits.
  - No error and rd == 0: wb_steal = 0; the state still passes through WB.
- stall = issue_mul | issue_div | (state != IDLE).
  - Combinational, so the issue cycle itself freezes fetch/decode.
- Issue pulses while busy are ignored. This cannot occur under a correct stall, but the bench checks it.
- Outside WB: wb_reg = 0 and wb_data = 0.

## Timing
- Reset (reset=0, asynchronous):
  - state = IDLE, counter = 0, latches = 0.
  - All outputs 0, except stall, which follows the issue inputs combinationally.
  - Any in-flight result is discarded and no write occurs.
- Reset release takes effect at the first rising edge with reset=1.
- Latency from the issue edge:
  - START occupies cycle 1, RUN begins in cycle 2.
  - If the core asserts ready k cycles into RUN (k ≥ 1), WB is cycle 2+k and IDLE is cycle 3+k.
- stall is high from the issue cycle through the WB cycle inclusive, and low in the first IDLE cycle.
- wb_steal is high for exactly one cycle per operation and never outside WB.
- A new issue in the first IDLE cycle after WB is accepted normally, giving back-to-back operations.
- Timeout: with no ready, WB occurs TIMEOUT cycles after RUN entry.

## Test plan
- Reset, then mult with rd=3 and the core returning 0x00000018 three RUN cycles after the pulse:
  - core_ctrl_mult pulses once.
  - stall is high 6 cycles.
  - wb_steal is high one cycle with wb_reg=3, wb_data=0x18.
- Div with rd=7, core_ready=1 and core_exception=1: wb_reg=30, wb_data=5; r7 is not written.
- Mult with rd=0, no exception: full state sequence and stall timing, wb_steal stays 0.
- Div with core_ready held low: after 40 RUN cycles, WB writes r30=5, then IDLE; busy drops.
- Two back-to-back ops, each with ready after 2 RUN cycles:
  - Issue a second mult in the first IDLE cycle; it is accepted.
  - Issue pulses injected during RUN are ignored (no extra core pulse).
- Assert reset=0 mid-RUN with core_ready asserted on the same edge: outputs drop immediately, no wb_steal, state IDLE.
